pkt_decapsulator: RTL and testbench

Receive-side counterpart of the router's packet encapsulator. It drains one 19-beat, 64-bit Aurora packet from output port 0's FIFO, checks sync byte and XOR trailer, and reassembles the 1034-bit DFX frame (1024-bit data plus 10-bit BRAM address). A valid frame is handed to the BRAM arbiter through a write request/grant handshake. The block sits between output port 0 and the arbiter write port, and is started and acknowledged by the router controller through `start_decap_pkt` and `decap_done`.

---
 rtl/pkt_decapsulator_if.sv | 50 +++++
 rtl/pkt_decapsulator.sv | 165 ++++++++++++++++
 tb/tb_pkt_decapsulator.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_decapsulator_if.sv
// Handshake and data bundle between output port 0 FIFO, router controller,
// BRAM arbiter write port and the packet decapsulator.
//   master: decapsulator side (drives fifo_rd, frame, write_req, done/err)
//   slave : environment side (drives start, fifo_empty/dout, write_gnt)
interface pkt_decapsulator_if #(
    parameter int DATA_WIDTH        = 1024,
    parameter int ADDR_WIDTH        = 10,
    parameter int AURORA_DATA_WIDTH = 64,
    parameter int HEADER_WIDTH      = 9
);
    logic                         start_decap_pkt;
    logic                         decap_done;
    logic                         decap_err;
    logic                         fifo_empty;
    logic                         fifo_rd;
    logic [AURORA_DATA_WIDTH-1:0] fifo_dout;
    logic [HEADER_WIDTH-1:0]      header_pkt_recv;
    logic [ADDR_WIDTH-1:0]        dst_addr_recv;
    logic [DATA_WIDTH-1:0]        data_recv;
    logic                         write_req;
    logic                         write_gnt;

    modport master (
        input  start_decap_pkt,
        input  fifo_empty,
        input  fifo_dout,
        input  write_gnt,
        output decap_done,
        output decap_err,
        output fifo_rd,
        output header_pkt_recv,
        output dst_addr_recv,
        output data_recv,
        output write_req
    );

    modport slave (
        output start_decap_pkt,
        output fifo_empty,
        output fifo_dout,
        output write_gnt,
        input  decap_done,
        input  decap_err,
        input  fifo_rd,
        input  header_pkt_recv,
        input  dst_addr_recv,
        input  data_recv,
        input  write_req
    );
endinterface

// File: rtl/pkt_decapsulator.sv
// Drains one 19-beat Aurora packet (header, 17 payload, XOR trailer) from the
// port 0 FIFO, checks sync + trailer, and hands the 1034-bit DFX frame to the
// BRAM arbiter via write_req/write_gnt.
// Ports: clk, rst_n (async, active-low), bus (pkt_decapsulator_if.master):
//   start_decap_pkt/decap_done/decap_err  controller handshake
//   fifo_empty/fifo_rd/fifo_dout          FIFO read side (1-cycle latency)
//   header_pkt_recv/dst_addr_recv/data_recv  reassembled fields
//   write_req/write_gnt                   arbiter write handshake
module pkt_decapsulator #(
    parameter int DATA_WIDTH        = 1024,
    parameter int ADDR_WIDTH        = 10,
    parameter int DATA_DFX_WIDTH    = DATA_WIDTH + ADDR_WIDTH,
    parameter int AURORA_DATA_WIDTH = 64,
    parameter int NUMBER_PACKET     = 19,
    parameter int HEADER_WIDTH      = 9
) (
    input logic                 clk,
    input logic                 rst_n,
    pkt_decapsulator_if.master  bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int CW = 5;
    localparam logic [CW-1:0] NBEATS    = CW'(NUMBER_PACKET);
    localparam logic [CW-1:0] LAST_BEAT = CW'(NUMBER_PACKET - 1);
    localparam int PAY_FULL = DATA_WIDTH / AURORA_DATA_WIDTH;
    localparam logic [CW-1:0] ADDR_BEAT = CW'(PAY_FULL + 1);
    localparam int HDR_LSB = AURORA_DATA_WIDTH - 8 - HEADER_WIDTH;
    localparam logic [7:0] SYNC = 8'hA5;

    logic [2:0]                   state_q, state_d;
    logic [CW-1:0]                rd_cnt_q, rd_cnt_d;
    logic [CW-1:0]                rx_cnt_q, rx_cnt_d;
    logic                         vld_q, vld_d;
    logic [AURORA_DATA_WIDTH-1:0] xor_q, xor_d;
    logic                         sync_ok_q, sync_ok_d;
    logic [HEADER_WIDTH-1:0]      hdr_q, hdr_d;
    logic [DATA_DFX_WIDTH-1:0]    frame_q, frame_d;
    logic                         wreq_q, wreq_d;
    logic                         done_q, done_d;
    logic                         derr_q, derr_d;
    logic                         rd_en;
    logic [AURORA_DATA_WIDTH-1:0] beat;

    assign beat  = bus.fifo_dout;
    assign rd_en = (state_q == S_READ) && (rd_cnt_q < NBEATS) &&
                   !bus.fifo_empty;

    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        rx_cnt_d  = rx_cnt_q;
        vld_d     = rd_en;
        xor_d     = xor_q;
        sync_ok_d = sync_ok_q;
        hdr_d     = hdr_q;
        frame_d   = frame_q;
        wreq_d    = wreq_q;
        done_d    = 1'b0;
        derr_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start_decap_pkt) begin
                    rd_cnt_d  = '0;
                    rx_cnt_d  = '0;
                    xor_d     = '0;
                    sync_ok_d = 1'b0;
                    state_d   = S_READ;
                end
            end
            S_READ: begin
                rd_cnt_d = rd_cnt_q + {{(CW-1){1'b0}}, rd_en};
                // vld_q marks the beat requested on the previous cycle;
                // rx_cnt_q says which beat of the packet it is.
                if (vld_q) begin
                    xor_d    = xor_q ^ beat;
                    rx_cnt_d = rx_cnt_q + 1'b1;
                    if (rx_cnt_q == '0) begin
                        sync_ok_d = (beat[AURORA_DATA_WIDTH-1 -: 8] == SYNC);
                        hdr_d     = beat[HDR_LSB +: HEADER_WIDTH];
                    end
                    for (int k = 1; k <= PAY_FULL; k++) begin
                        if (rx_cnt_q == CW'(k)) begin
                            frame_d[(k-1)*AURORA_DATA_WIDTH +:
                                    AURORA_DATA_WIDTH] = beat;
                        end
                    end
                    if (rx_cnt_q == ADDR_BEAT) begin
                        frame_d[DATA_DFX_WIDTH-1 -: ADDR_WIDTH] =
                            beat[ADDR_WIDTH-1:0];
                    end
                    if (rx_cnt_q == LAST_BEAT) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                // xor_q includes the trailer, so a matching trailer leaves 0
                if (!sync_ok_q || (xor_q != '0)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    derr_d  = 1'b1;
                end else begin
                    state_d = S_WRITE;
                    wreq_d  = 1'b1;
                end
            end
            S_WRITE: begin
                if (bus.write_gnt) begin
                    wreq_d  = 1'b0;
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rd_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            vld_q     <= 1'b0;
            xor_q     <= '0;
            sync_ok_q <= 1'b0;
            hdr_q     <= '0;
            frame_q   <= '0;
            wreq_q    <= 1'b0;
            done_q    <= 1'b0;
            derr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_cnt_q  <= rd_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
            vld_q     <= vld_d;
            xor_q     <= xor_d;
            sync_ok_q <= sync_ok_d;
            hdr_q     <= hdr_d;
            frame_q   <= frame_d;
            wreq_q    <= wreq_d;
            done_q    <= done_d;
            derr_q    <= derr_d;
        end
    end

    assign bus.fifo_rd         = rd_en;
    assign bus.decap_done      = done_q;
    assign bus.decap_err       = derr_q;
    assign bus.write_req       = wreq_q;
    assign bus.header_pkt_recv = hdr_q;
    assign bus.data_recv       = frame_q[DATA_WIDTH-1:0];
    assign bus.dst_addr_recv   = frame_q[DATA_DFX_WIDTH-1:DATA_WIDTH];

endmodule

// File: tb/tb_pkt_decapsulator.sv
// Directed bench for pkt_decapsulator: FIFO model, table of packets,
// plus a hand-written mid-packet reset sequence.
module tb_pkt_decapsulator;

    localparam int DW = 1024;
    localparam int AW = 10;
    localparam int HW = 9;

    typedef struct {
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
        logic [HW-1:0] hdr;
        logic [7:0]    sync;
        logic [63:0]   flip;
        int            gdly;
        int            stall;
        bit            bad;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pkt_decapsulator_if bus ();

    pkt_decapsulator dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: read strobe sampled mid-cycle, data out after the edge
    logic [63:0] q[$];
    int   fcnt = 0;
    int   pops = 0;
    int   stall_at = -1;
    int   stall_len = 0;
    int   stall_cnt = 0;
    logic rd_s = 1'b0;

    always @(negedge clk) rd_s <= bus.fifo_rd;

    always @(posedge clk) begin
        if (rd_s && q.size() != 0) begin
            bus.fifo_dout <= q.pop_front();
            pops <= pops + 1;
        end
        if (rd_s && (pops + 1 == stall_at)) stall_cnt <= stall_len;
        else if (stall_cnt > 0) stall_cnt <= stall_cnt - 1;
        fcnt <= q.size();
    end

    assign bus.fifo_empty = (fcnt == 0) || (stall_cnt != 0);

    // Per-packet monitor, cleared when start is seen
    int rd_n = 0, rd_first = -1, rd_last = -1;
    int wr_n = 0, wr_first = -1, done_n = 0, done_cyc = -1;
    logic done_err = 1'b0, wr_chg = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic [AW-1:0] wr_addr = '0;
    logic [HW-1:0] wr_hdr = '0;

    always @(negedge clk) begin
        if (bus.start_decap_pkt) begin
            rd_n <= 0; rd_first <= -1; rd_last <= -1;
            wr_n <= 0; wr_first <= -1; done_n <= 0;
            done_cyc <= -1; done_err <= 1'b0; wr_chg <= 1'b0;
        end else begin
            if (bus.fifo_rd) begin
                rd_n <= rd_n + 1;
                if (rd_first < 0) rd_first <= cyc;
                rd_last <= cyc;
            end
            if (bus.write_req) begin
                wr_n <= wr_n + 1;
                if (wr_n == 0) begin
                    wr_first <= cyc;
                    wr_data  <= bus.data_recv;
                    wr_addr  <= bus.dst_addr_recv;
                    wr_hdr   <= bus.header_pkt_recv;
                end else if (bus.data_recv !== wr_data ||
                             bus.dst_addr_recv !== wr_addr ||
                             bus.header_pkt_recv !== wr_hdr) begin
                    wr_chg <= 1'b1;
                end
            end
            if (bus.decap_done) begin
                done_n   <= done_n + 1;
                done_cyc <= cyc;
                done_err <= bus.decap_err;
            end
        end
    end

    task automatic chk_i(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic chk_v(input string nm, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        int w;
        checks++;
        if (got !== exp) begin
            failures++;
            w = 0;
            for (int i = DW/64 - 1; i >= 0; i--)
                if (got[i*64 +: 64] !== exp[i*64 +: 64]) w = i;
            $display("FAIL %s word%0d got=%h exp=%h", nm, w,
                     got[w*64 +: 64], exp[w*64 +: 64]);
        end
    endtask

    function automatic logic [DW-1:0] mk_data(input logic [63:0] seed);
        logic [DW-1:0] d;
        for (int i = 0; i < DW/64; i++)
            d[i*64 +: 64] = seed ^ (64'(i) * 64'h1111_1111_1111_1111);
        return d;
    endfunction

    function automatic void push_pkt(input vec_t v);
        logic [63:0] b;
        logic [63:0] x;
        b = {v.sync, v.hdr, 47'h1234_5678_9ABC};
        x = b;
        q.push_back(b);
        for (int k = 0; k < DW/64; k++) begin
            b = v.data[k*64 +: 64];
            x = x ^ b;
            q.push_back(b);
        end
        b = {54'h15_5555_5555_5555, v.addr};
        x = x ^ b;
        q.push_back(b);
        q.push_back(x ^ v.flip);
    endfunction

    task automatic run_pkt(input vec_t v, input string tag);
        int t;
        int exp_done;
        bit seen;
        bus.write_gnt = (v.gdly == 0);
        stall_len = v.stall;
        stall_at = (v.stall > 0) ? pops + 8 : -1;
        bus.start_decap_pkt = 1'b1;
        t = cyc;
        @(posedge clk); #1;
        bus.start_decap_pkt = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (v.gdly > 0 && cyc == t + 22 + v.stall + v.gdly)
                bus.write_gnt = 1'b1;
            @(negedge clk);
            if (bus.decap_done) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk_i({tag, "/done_seen"}, int'(seen), 1);
        exp_done = v.bad ? t + 22 + v.stall : t + 23 + v.stall + v.gdly;
        chk_i({tag, "/rd_n"}, rd_n, 19);
        chk_i({tag, "/rd_first"}, rd_first, t + 1);
        chk_i({tag, "/rd_last"}, rd_last, t + 19 + v.stall);
        chk_i({tag, "/wr_n"}, wr_n, v.bad ? 0 : 1 + v.gdly);
        chk_i({tag, "/wr_first"}, wr_first, v.bad ? -1 : t + 22 + v.stall);
        chk_i({tag, "/wr_stable"}, int'(wr_chg), 0);
        chk_i({tag, "/done_cyc"}, done_cyc, exp_done);
        chk_i({tag, "/done_n"}, done_n, 1);
        chk_i({tag, "/done_err"}, int'(done_err), int'(v.bad));
        chk_i({tag, "/done_low"}, int'(bus.decap_done), 0);
        chk_i({tag, "/hdr"}, int'(bus.header_pkt_recv), int'(v.hdr));
        chk_i({tag, "/addr"}, int'(bus.dst_addr_recv), int'(v.addr));
        chk_v({tag, "/data"}, bus.data_recv, v.data);
    endtask

    vec_t tbl[7];
    vec_t va, vn;
    int   t0;

    initial begin
        bus.start_decap_pkt = 1'b0;
        bus.write_gnt = 1'b0;
        tbl[0] = '{mk_data(64'h0123_4567_89AB_CDEF), 10'h2A5, 9'h1B3,
                   8'hA5, 64'h0, 0, 0, 1'b0};
        tbl[1] = '{mk_data(64'hFEDC_BA98_7654_3210), 10'h3FF, 9'h1FF,
                   8'hA5, 64'h0, 5, 0, 1'b0};
        tbl[2] = '{mk_data(64'h0F0F_0F0F_F0F0_F0F0), 10'h001, 9'h0FE,
                   8'hA5, 64'h1, 0, 0, 1'b1};
        tbl[3] = '{mk_data(64'hDEAD_BEEF_CAFE_F00D), 10'h123, 9'h055,
                   8'hA4, 64'h0, 0, 0, 1'b1};
        tbl[4] = '{mk_data(64'h5555_AAAA_3333_CCCC), 10'h155, 9'h0AA,
                   8'hA5, 64'h0, 0, 0, 1'b0};
        tbl[5] = '{mk_data(64'h8000_0000_0000_0001), 10'h200, 9'h100,
                   8'hA5, 64'h0, 0, 3, 1'b0};
        tbl[6] = '{mk_data(64'h1357_9BDF_0246_8ACE), 10'h0C3, 9'h001,
                   8'hA5, 64'h0, 1, 0, 1'b0};
        va = '{mk_data(64'hAAAA_0000_BBBB_1111), 10'h3C0, 9'h0F0,
               8'hA5, 64'h0, 0, 0, 1'b0};
        vn = '{mk_data(64'h7777_6666_5555_4444), 10'h0F1, 9'h13C,
               8'hA5, 64'h0, 0, 0, 1'b0};
        for (int i = 0; i < 7; i++) push_pkt(tbl[i]);

        repeat (3) @(posedge clk);
        #1;
        chk_i("rst/fifo_rd", int'(bus.fifo_rd), 0);
        chk_i("rst/write_req", int'(bus.write_req), 0);
        chk_i("rst/done", int'(bus.decap_done), 0);
        chk_i("rst/err", int'(bus.decap_err), 0);
        chk_i("rst/hdr", int'(bus.header_pkt_recv), 0);
        chk_i("rst/addr", int'(bus.dst_addr_recv), 0);
        chk_v("rst/data", bus.data_recv, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) run_pkt(tbl[i], $sformatf("v%0d", i));

        // abort a packet with reset while beat ~10 is being read
        push_pkt(va);
        repeat (2) @(posedge clk);
        #1;
        bus.write_gnt = 1'b1;
        bus.start_decap_pkt = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        bus.start_decap_pkt = 1'b0;
        while (cyc < t0 + 11) begin
            @(posedge clk); #1;
        end
        chk_i("abort/fifo_rd_before", int'(bus.fifo_rd), 1);
        rst_n = 1'b0;
        #1;
        chk_i("abort/fifo_rd", int'(bus.fifo_rd), 0);
        chk_i("abort/write_req", int'(bus.write_req), 0);
        chk_i("abort/done", int'(bus.decap_done), 0);
        chk_i("abort/err", int'(bus.decap_err), 0);
        chk_i("abort/hdr", int'(bus.header_pkt_recv), 0);
        chk_i("abort/addr", int'(bus.dst_addr_recv), 0);
        chk_v("abort/data", bus.data_recv, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        push_pkt(vn);
        repeat (2) @(posedge clk);
        #1;
        chk_i("post_rst/idle_no_rd", int'(bus.fifo_rd), 0);
        run_pkt(vn, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
